// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline interlock sequencer: state encoding,
// default register-address width and the load-use hazard check.
package pipe_ctrl_pkg;

  localparam int RADDR_W = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_WAIT    = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hazard(
    input logic               dec_valid,
    input logic               ex_is_load,
    input logic [RADDR_W-1:0] ex_dest,
    input logic [RADDR_W-1:0] r1_dec,
    input logic [RADDR_W-1:0] r2_dec
  );
    return dec_valid && ex_is_load && (ex_dest != '0) &&
           ((r1_dec == ex_dest) || (r2_dec == ex_dest));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline interlock sequencer: load-use stalls, multi-cycle execute handshake
// and multi-cycle redirect flushes for the IF/DEC/EX pipeline registers.
//
//  state         | meaning
//  --------------+-------------------------------------------------------
//  ST_RUN        | normal issue; hazards and redirects detected here
//  ST_LOAD_STALL | holding DEC for the remaining load-use latency
//  ST_MC_WAIT    | multi-cycle op in flight, waiting for mc_done
//  ST_FLUSH      | squashing wrong-path IF/DEC contents after a redirect
module pipeline_stall_ctrl #(
  parameter int RADDR_W      = pipe_ctrl_pkg::RADDR_W,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  input  logic [RADDR_W-1:0] r1_dec,
  input  logic [RADDR_W-1:0] r2_dec,
  input  logic               dec_is_mc,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_dest,
  input  logic               jump,
  input  logic               branched,
  input  logic               mc_done,
  output logic               mc_start,
  output logic               mc_abort,
  output logic               stall_fetch,
  output logic               stall_dec,
  output logic               bubble_ex,
  output logic               flush_if,
  output logic               flush_dec,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               busy
);

  import pipe_ctrl_pkg::*;

  localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       redir, lu;
  logic       do_stall, do_flush, do_start, do_abort;

  assign redir = jump | branched;
  assign lu    = load_use_hazard(dec_valid, ex_is_load, ex_dest, r1_dec, r2_dec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the cycles still to spend in LOAD_STALL/FLUSH, counting the
  // current one, so the state is left when it reaches 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_stall  = 1'b0;
    do_flush  = 1'b0;
    do_start  = 1'b0;
    do_abort  = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (redir) begin
          do_flush  = 1'b1;
          cnt_nxt   = FLUSH_RELOAD;
          state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (dec_valid && dec_is_mc) begin
          do_start  = 1'b1;
          do_stall  = 1'b1;
          state_nxt = ST_MC_WAIT;
        end else if (lu) begin
          do_stall  = 1'b1;
          cnt_nxt   = LOAD_RELOAD;
          state_nxt = (LOAD_LAT > 1) ? ST_LOAD_STALL : ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        if (redir) begin
          do_flush  = 1'b1;
          cnt_nxt   = FLUSH_RELOAD;
          state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
          do_stall = 1'b1;
          if (cnt <= 4'd1) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      ST_MC_WAIT: begin
        // A redirect here comes from an older branch, so it outranks mc_done.
        if (redir) begin
          do_abort  = 1'b1;
          do_flush  = 1'b1;
          cnt_nxt   = FLUSH_RELOAD;
          state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (mc_done) begin
          state_nxt = ST_RUN;
        end else begin
          do_stall = 1'b1;
        end
      end
      ST_FLUSH: begin
        do_flush = 1'b1;
        if (cnt <= 4'd1) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Everything is quiet while reset is sampled; no abort is signalled.
  assign mc_start    = do_start & ~reset;
  assign mc_abort    = do_abort & ~reset;
  assign stall_fetch = do_stall & ~reset;
  assign stall_dec   = do_stall & ~reset;
  assign bubble_ex   = do_stall & ~reset;
  assign flush_if    = do_flush & ~reset;
  assign flush_dec   = do_flush & ~reset;
  assign busy        = (state != ST_RUN) & ~reset;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_fetch),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a driver pushes expected outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

  localparam int LL   = 3;
  localparam int FC   = 2;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid = 1'b0;
  logic [3:0]  r1_dec = '0, r2_dec = '0, ex_dest = '0;
  logic        dec_is_mc = 1'b0, ex_is_load = 1'b0;
  logic        jump = 1'b0, branched = 1'b0, mc_done = 1'b0;
  logic        mc_start, mc_abort, stall_fetch, stall_dec, bubble_ex;
  logic        flush_if, flush_dec, busy;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .RADDR_W(4), .LOAD_LAT(LL), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .r1_dec(r1_dec),
    .r2_dec(r2_dec), .dec_is_mc(dec_is_mc), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .jump(jump), .branched(branched), .mc_done(mc_done),
    .mc_start(mc_start), .mc_abort(mc_abort), .stall_fetch(stall_fetch),
    .stall_dec(stall_dec), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .flush_dec(flush_dec), .stall_cycles(stall_cycles), .busy(busy)
  );

  typedef struct {
    logic [7:0] outs;   // {mc_start, mc_abort, sf, sd, bx, fi, fd, busy}
    int         cnt;
    bit         chk_cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  // Behavioural model: remaining-cycle budgets rather than a state machine.
  int load_left = 0, flush_left = 0, cnt_model = 0;
  bit mc_busy = 0, cnt_known = 0;

  task automatic apply(input logic rst, input logic dv, input logic [3:0] r1,
                       input logic [3:0] r2, input logic mc, input logic ld,
                       input logic [3:0] dst, input logic j, input logic b,
                       input logic d);
    exp_t e;
    bit st, fl, start, abrt, bsy, redir, lu;
    @(posedge clk);
    #1;
    reset = rst; dec_valid = dv; r1_dec = r1; r2_dec = r2; dec_is_mc = mc;
    ex_is_load = ld; ex_dest = dst; jump = j; branched = b; mc_done = d;
    cyc_no++;
    e.cnt = cnt_model; e.chk_cnt = cnt_known; e.cyc = cyc_no;
    st = 0; fl = 0; start = 0; abrt = 0;
    bsy = (load_left > 0) || (flush_left > 0) || mc_busy;
    if (rst) begin
      e.outs = '0;
      sb.push_back(e);
      load_left = 0; flush_left = 0; mc_busy = 0;
      cnt_model = 0; cnt_known = 1;
      return;
    end
    redir = j || b;
    lu = dv && ld && (dst != 0) && (r1 == dst || r2 == dst);
    if (flush_left > 0) begin
      fl = 1; flush_left--;
    end else if (mc_busy) begin
      if (redir) begin abrt = 1; fl = 1; flush_left = FC - 1; mc_busy = 0; end
      else if (d) mc_busy = 0;
      else st = 1;
    end else if (load_left > 0) begin
      if (redir) begin fl = 1; flush_left = FC - 1; load_left = 0; end
      else begin st = 1; load_left--; end
    end else begin
      if (redir) begin fl = 1; flush_left = FC - 1; end
      else if (dv && mc) begin start = 1; st = 1; mc_busy = 1; end
      else if (lu) begin st = 1; load_left = LL - 1; end
    end
    e.outs = {start, abrt, st, st, st, fl, fl, bsy};
    sb.push_back(e);
    if (st && cnt_model < CMAX) cnt_model++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = {mc_start, mc_abort, stall_fetch, stall_dec, bubble_ex,
             flush_if, flush_dec, busy};
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%b want=%b", e.cyc, act, e.outs);
      end
      if (e.chk_cnt) begin
        total++;
        if (stall_cycles !== CW'(e.cnt)) begin
          bad++;
          $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d",
                   e.cyc, stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 5, 5, 1, 1, 5, 1, 0, 1);
    idle(2);
    // load-use on r2
    apply(0, 1, 1, 5, 0, 1, 5, 0, 0, 0);
    idle(4);
    // load to x0 is exempt
    apply(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // multi-cycle op, done after 7 cycles; stray mc_done afterwards
    apply(0, 1, 2, 3, 1, 0, 0, 0, 0, 0);
    idle(6);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // taken branch, jump during flush ignored
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // branch and mc_done together in MC_WAIT
    apply(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    // redirect during load stall; hazard persisting on return to RUN
    apply(0, 1, 7, 0, 0, 1, 7, 0, 0, 0);
    apply(0, 1, 7, 0, 0, 1, 7, 1, 0, 0);
    apply(0, 1, 7, 0, 0, 1, 7, 0, 0, 0);
    apply(0, 1, 7, 0, 0, 1, 7, 0, 0, 0);
    idle(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 5) == 0));
    end
    idle(12);
    // reset asserted during FLUSH
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(1, 1, 3, 3, 1, 1, 3, 1, 1, 1);
    idle(2);
    // long multi-cycle wait drives the stall counter into saturation
    apply(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(CMAX + 2);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 1, 9, 0, 0, 1, 9, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
